bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Parametrised sequential binary-to-BCD converter using iterative shift-add-3 (double dabble), one input bit per clock. It accepts an unsigned binary word over a valid/ready handshake and returns packed BCD, ASCII digit characters, a significant-digit count and an overflow flag. It sits between the datapath counters/registers and the character display/UART formatting logic, and replaces the fixed single-digit ASCII decode with a general conversion.

## Interface
- BIN_W, 16: width of the binary input, ≥ 1.
- DIGITS, 5: number of BCD digits produced, ≥ 1.
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  converter can accept; high only in IDLE.
- in_data  in  BIN_W  unsigned binary value.
- blank_en  in  1  leading-zero blanking request, sampled with in_data.
- out_valid  out  1  result available; held until out_ready.
- out_ready  in  1  consumer accepts result.
- bcd_o  out  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0].
- ascii_o  out  8*DIGITS  one character per digit, same ordering as bcd_o.
- ndig_o  out  $clog2(DIGITS+1)  count of significant digits, 1..DIGITS.
- ovf_o  out  1  value ≥ 10^DIGITS.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid: load in_data into shift register, clear BCD register and ovf sticky bit, latch blank_en, clear bit counter, go to SHIFT.
- SHIFT: each cycle, every digit ≥ 5 gets +3, then {BCD, shift} shifts left one bit; the bit leaving the top digit's MSB sets the ovf sticky bit. After BIN_W shift cycles, go to DONE.
- DONE: outputs valid. On out_ready, go to IDLE.
- Overflow: bcd_o forced to all 9s, ascii_o all '9' (0x39), ndig_o=DIGITS, ovf_o=1.
- ascii_o: digit d maps to 0x30+d. With blank_en, leading zero digits map to 0x20 (space). Digit 0 is never blanked.
- ndig_o: index of the highest nonzero digit + 1; 1 when the value is 0. Independent of blank_en.
- Outputs are registered and hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset: state=IDLE, out_valid=0, bcd_o=0, ascii_o=0, ndig_o=0, ovf_o=0. in_ready=0 during the reset cycle and 1 from the next cycle.
- Latency: when the accept edge is in cycle T, out_valid is first high in cycle T+BIN_W+1.
- Throughput: one conversion per BIN_W+2 cycles at best. in_ready=0 in SHIFT and DONE, with no overlap.
- Input change: in_data and blank_en changes after acceptance have no effect.
- out_valid can deassert only after an out_ready handshake or rst.
- Reset mid-SHIFT or mid-DONE: the conversion is discarded, no out_valid, and all outputs return to reset values.
- Simultaneous out_ready in DONE with in_valid: the result is retired that cycle, and the new word is accepted on the next cycle (IDLE).
- BIN_W=1: a single shift cycle, latency 2.

## Structure
- Package bin2bcd_pkg holds:
  - the state enum (IDLE/SHIFT/DONE);
  - ASCII_ZERO=8'h30, ASCII_SPACE=8'h20, ASCII_NINE=8'h39;
  - the function digits_for_width(w), used by the bench to check the no-overflow DIGITS.
- Sub-module bcd_add3_cell: a combinational 4-bit "≥5 then +3" adjust, instantiated DIGITS times by generate.
- Bit counter width: $clog2(BIN_W+1).

## Test plan
- Default params, in_data=47 accepted in cycle 0:
  - out_valid first in cycle 17;
  - bcd_o=20'h00047, ascii_o="00047", ndig_o=2, ovf_o=0.
- in_data=65535, blank_en=0 -> bcd_o=20'h65535, ascii_o="65535", ndig_o=5.
- in_data=0, blank_en=1 -> bcd_o=0, ascii_o="    0", ndig_o=1. Then in_data=905, blank_en=1 -> ascii_o="  905", ndig_o=3.
- DIGITS=4, BIN_W=16, in_data=12345 -> ovf_o=1, bcd_o=16'h9999, ascii_o="9999", ndig_o=4. A following 9999 converts with ovf_o=0.
- Back-pressure: out_ready held low 10 cycles after out_valid -> outputs stable, in_ready=0, in_valid pulses ignored. out_ready=1 -> next cycle IDLE, in_ready=1.
- rst asserted 5 cycles into SHIFT:
  - out_valid never rises and outputs are zero;
  - the next word, 1234, converts correctly with full latency.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared types, character constants and sizing helper for the binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_NINE  = 8'h39;

    // Decimal digits needed to show the largest w-bit unsigned value without overflow.
    // Widths beyond 63 bits saturate at the 63-bit answer.
    function automatic int digits_for_width(input int w);
        longint unsigned max_v;
        longint unsigned pow10;
        int d;
        max_v = (w >= 63) ? 64'h7FFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        d     = 1;
        pow10 = 64'd10;
        for (int i = 0; i < 18; i++) begin
            if (pow10 <= max_v) begin
                d     = d + 1;
                pow10 = pow10 * 64'd10;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Input and result handshakes of the binary-to-BCD converter.
interface bin2bcd_seq_if #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
);
    localparam int NDIG_W = $clog2(DIGITS + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      in_data;
    logic                  blank_en;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd_o;
    logic [8*DIGITS-1:0]   ascii_o;
    logic [NDIG_W-1:0]     ndig_o;
    logic                  ovf_o;

    // Producer of words and consumer of results.
    modport master (
        output in_valid, in_data, blank_en, out_ready,
        input  in_ready, out_valid, bcd_o, ascii_o, ndig_o, ovf_o
    );

    // The converter itself.
    modport slave (
        input  in_valid, in_data, blank_en, out_ready,
        output in_ready, out_valid, bcd_o, ascii_o, ndig_o, ovf_o
    );

endinterface

// File: rtl/bcd_add3_cell.sv
// One BCD digit pre-shift correction: digits of 5 or more get +3 so the
// following left shift carries correctly into the next decade.
module bcd_add3_cell (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one input bit per clock, then a
// registered result with packed BCD, ASCII digits, digit count and overflow.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | in_ready high, waiting for a word
// SHIFT | adjust-and-shift one bit per cycle, BIN_W cycles
// DONE  | result registered, out_valid held until out_ready
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic           clk,
    input  logic           rst,
    bin2bcd_seq_if.slave   bus
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int CNT_W  = $clog2(BIN_W + 1);
    localparam int NDIG_W = $clog2(DIGITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    state_t                 state;
    logic [BIN_W-1:0]       sh_q;
    logic [BCD_W-1:0]       bcd_q;
    logic                   ovf_q;
    logic                   blank_q;
    logic [CNT_W-1:0]       cnt_q;

    logic                   in_ready_q;
    logic                   out_valid_q;
    logic [BCD_W-1:0]       bcd_out_q;
    logic [8*DIGITS-1:0]    ascii_out_q;
    logic [NDIG_W-1:0]      ndig_out_q;
    logic                   ovf_out_q;

    logic [BCD_W-1:0]       bcd_adj;
    logic [BCD_W-1:0]       bcd_shift;
    logic [BIN_W-1:0]       sh_shift;
    logic                   ovf_next;

    logic [BCD_W-1:0]       fmt_bcd;
    logic [8*DIGITS-1:0]    fmt_ascii;
    logic [NDIG_W-1:0]      fmt_ndig;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_adj
            bcd_add3_cell u_cell (
                .din  (bcd_q[4*g +: 4]),
                .dout (bcd_adj[4*g +: 4])
            );
        end
    endgenerate

    // The MSB of the top adjusted digit is the carry out of the whole BCD
    // field; once set the value no longer fits in DIGITS digits.
    assign bcd_shift = {bcd_adj[BCD_W-2:0], sh_q[BIN_W-1]};
    assign sh_shift  = sh_q << 1;
    assign ovf_next  = ovf_q | bcd_adj[BCD_W-1];

    // Format the final shift result so it can be registered on the last SHIFT edge.
    always_comb begin
        fmt_ndig  = NDIG_W'(1);
        fmt_bcd   = bcd_shift;
        fmt_ascii = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (bcd_shift[4*d +: 4] != 4'd0) begin
                fmt_ndig = NDIG_W'(d + 1);
            end
        end
        // Blanking only touches digits above the highest significant one,
        // so digit 0 is never blanked since fmt_ndig is at least 1.
        for (int d = 0; d < DIGITS; d++) begin
            if (blank_q && (d >= int'(fmt_ndig))) begin
                fmt_ascii[8*d +: 8] = ASCII_SPACE;
            end else begin
                fmt_ascii[8*d +: 8] = ASCII_ZERO + {4'd0, bcd_shift[4*d +: 4]};
            end
        end
        if (ovf_next) begin
            fmt_bcd   = {DIGITS{4'h9}};
            fmt_ascii = {DIGITS{ASCII_NINE}};
            fmt_ndig  = NDIG_W'(DIGITS);
        end
    end

    // Control FSM with the datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sh_q        <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            blank_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            bcd_out_q   <= '0;
            ascii_out_q <= '0;
            ndig_out_q  <= '0;
            ovf_out_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        sh_q       <= bus.in_data;
                        bcd_q      <= '0;
                        ovf_q      <= 1'b0;
                        blank_q    <= bus.blank_en;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_q  <= sh_shift;
                    bcd_q <= bcd_shift;
                    ovf_q <= ovf_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        out_valid_q <= 1'b1;
                        bcd_out_q   <= fmt_bcd;
                        ascii_out_q <= fmt_ascii;
                        ndig_out_q  <= fmt_ndig;
                        ovf_out_q   <= ovf_next;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.bcd_o     = bcd_out_q;
    assign bus.ascii_o   = ascii_out_q;
    assign bus.ndig_o    = ndig_out_q;
    assign bus.ovf_o     = ovf_out_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: a 5-digit and a 4-digit converter driven in lockstep
// from the same stimulus, each compared against an arithmetic decimal model.
module tb_bin2bcd_seq;
    import bin2bcd_pkg::*;

    localparam int BIN_W = 16;
    localparam int DIG_A = digits_for_width(BIN_W);
    localparam int DIG_B = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [BIN_W-1:0]  in_data;
    logic              blank_en;
    logic              out_ready;

    int n_vec = 0;
    int n_err = 0;
    int unsigned cur_v;
    bit          cur_blank;

    always #5 clk = ~clk;

    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIG_A)) ifa ();
    bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIG_B)) ifb ();

    assign ifa.in_valid  = in_valid;
    assign ifa.in_data   = in_data;
    assign ifa.blank_en  = blank_en;
    assign ifa.out_ready = out_ready;
    assign ifb.in_valid  = in_valid;
    assign ifb.in_data   = in_data;
    assign ifb.blank_en  = blank_en;
    assign ifb.out_ready = out_ready;

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIG_A)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIG_B)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // Decimal reference: digits by repeated division, overflow against 10^nd.
    function automatic void model(input int unsigned v, input int nd, input bit blank,
                                  output logic [63:0] bcd, output logic [63:0] asc,
                                  output int ndig, output bit ovf);
        longint unsigned lim;
        int unsigned t;
        int unsigned dig[8];
        lim = 1;
        for (int i = 0; i < nd; i++) lim = lim * 10;
        bcd = '0;
        asc = '0;
        if (longint'(v) >= lim) begin
            ovf  = 1'b1;
            ndig = nd;
            for (int i = 0; i < nd; i++) begin
                bcd[4*i +: 4] = 4'd9;
                asc[8*i +: 8] = 8'h39;
            end
            return;
        end
        ovf  = 1'b0;
        ndig = 1;
        t    = v;
        for (int i = 0; i < nd; i++) begin
            dig[i] = t % 10;
            t      = t / 10;
            bcd[4*i +: 4] = 4'(dig[i]);
            if (dig[i] != 0) ndig = i + 1;
        end
        for (int i = 0; i < nd; i++) begin
            asc[8*i +: 8] = (blank && i >= ndig) ? 8'h20 : 8'(8'h30 + dig[i]);
        end
    endfunction

    task automatic check_outputs();
        logic [63:0] eb;
        logic [63:0] ea;
        int en;
        bit eo;
        model(cur_v, DIG_A, cur_blank, eb, ea, en, eo);
        check("a_out_valid", 64'(ifa.out_valid), 64'd1);
        check("a_bcd",       64'(ifa.bcd_o),     eb);
        check("a_ascii",     64'(ifa.ascii_o),   ea);
        check("a_ndig",      64'(ifa.ndig_o),    64'(en));
        check("a_ovf",       64'(ifa.ovf_o),     64'(eo));
        model(cur_v, DIG_B, cur_blank, eb, ea, en, eo);
        check("b_out_valid", 64'(ifb.out_valid), 64'd1);
        check("b_bcd",       64'(ifb.bcd_o),     eb);
        check("b_ascii",     64'(ifb.ascii_o),   ea);
        check("b_ndig",      64'(ifb.ndig_o),    64'(en));
        check("b_ovf",       64'(ifb.ovf_o),     64'(eo));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_a_valid"}, 64'(ifa.out_valid), 64'd0);
        check({tag, "_a_bcd"},   64'(ifa.bcd_o),     64'd0);
        check({tag, "_a_ascii"}, 64'(ifa.ascii_o),   64'd0);
        check({tag, "_a_ndig"},  64'(ifa.ndig_o),    64'd0);
        check({tag, "_a_ovf"},   64'(ifa.ovf_o),     64'd0);
        check({tag, "_b_valid"}, 64'(ifb.out_valid), 64'd0);
        check({tag, "_b_bcd"},   64'(ifb.bcd_o),     64'd0);
    endtask

    // Offer a word, scramble the inputs right after acceptance, and check
    // latency and result once out_valid rises.
    task automatic start_word(input logic [BIN_W-1:0] v, input bit blank);
        int lat;
        lat = 0;
        while (ifa.in_ready !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("in_ready_idle", 64'(ifa.in_ready), 64'd1);
        cur_v     = v;
        cur_blank = blank;
        in_valid  = 1'b1;
        in_data   = v;
        blank_en  = blank;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = BIN_W'($urandom);
        blank_en = 1'($urandom);
        check("in_ready_busy", 64'(ifa.in_ready), 64'd0);
        lat = 1;
        while (ifa.out_valid !== 1'b1 && lat < 60) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'(BIN_W + 1));
        check_outputs();
    endtask

    // Hold the result for 'hold' cycles with stray in_valid pulses, then retire it.
    task automatic retire(input int hold);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            in_data  = BIN_W'($urandom);
            @(posedge clk); #1;
            check_outputs();
            check("hold_in_ready", 64'(ifa.in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("retired_a",   64'(ifa.out_valid), 64'd0);
        check("retired_b",   64'(ifb.out_valid), 64'd0);
        check("ready_after", 64'(ifa.in_ready),  64'd1);
    endtask

    initial begin
        logic [BIN_W-1:0] v;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        blank_en  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(ifa.in_ready), 64'd0);
        check_zero_outputs("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(ifa.in_ready), 64'd1);

        start_word(16'd47, 1'b0);
        check("lit47_bcd",   64'(ifa.bcd_o),   64'h00047);
        check("lit47_ascii", 64'(ifa.ascii_o), 64'("00047"));
        check("lit47_ndig",  64'(ifa.ndig_o),  64'd2);
        retire(0);

        start_word(16'd65535, 1'b0);
        check("litmax_bcd",   64'(ifa.bcd_o),   64'h65535);
        check("litmax_ascii", 64'(ifa.ascii_o), 64'("65535"));
        check("litmax_ndig",  64'(ifa.ndig_o),  64'd5);
        retire(0);

        start_word(16'd0, 1'b1);
        check("lit0_ascii", 64'(ifa.ascii_o), 64'("    0"));
        check("lit0_ndig",  64'(ifa.ndig_o),  64'd1);
        retire(0);

        start_word(16'd905, 1'b1);
        check("lit905_ascii", 64'(ifa.ascii_o), 64'("  905"));
        check("lit905_ndig",  64'(ifa.ndig_o),  64'd3);
        retire(0);

        // 4-digit instance overflows; also exercises back-pressure.
        start_word(16'd12345, 1'b0);
        check("ovf_b",       64'(ifb.ovf_o),   64'd1);
        check("ovf_b_bcd",   64'(ifb.bcd_o),   64'h9999);
        check("ovf_b_ascii", 64'(ifb.ascii_o), 64'("9999"));
        check("ovf_b_ndig",  64'(ifb.ndig_o),  64'd4);
        retire(10);

        start_word(16'd9999, 1'b0);
        check("fit_b_ovf", 64'(ifb.ovf_o), 64'd0);
        check("fit_b_bcd", 64'(ifb.bcd_o), 64'h9999);
        // Retire and offer a new word on the same edge: accepted one cycle later.
        in_valid  = 1'b1;
        in_data   = 16'd321;
        blank_en  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("simul_retired", 64'(ifa.out_valid), 64'd0);
        check("simul_ready",   64'(ifa.in_ready),  64'd1);
        start_word(16'd321, 1'b1);
        retire(0);

        // Reset five cycles into SHIFT discards the conversion.
        in_valid = 1'b1;
        in_data  = 16'd54321;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero_outputs("midrst");
        for (int i = 0; i < 25; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", 64'(ifa.out_valid | ifb.out_valid), 64'd0);
        end
        start_word(16'd1234, 1'b0);
        retire(0);

        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0:       v = BIN_W'($urandom_range(0, 9));
                1:       v = BIN_W'($urandom_range(10, 999));
                2:       v = BIN_W'($urandom_range(9990, 10010));
                default: v = BIN_W'($urandom);
            endcase
            start_word(v, 1'($urandom));
            retire($urandom_range(0, 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
